// File: rtl/bp_cache_req_arbiter.sv
// bp_cache_req_arbiter: round-robin arbitration of I$/D$ requests onto one shared LCE port
module bp_cache_req_arbiter #(
    parameter int req_width_p      = 64,
    parameter int metadata_width_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [2*req_width_p-1:0]      cache_req_i,
    input  logic [1:0]                    cache_req_v_i,
    output logic [1:0]                    cache_req_ready_o,
    input  logic [2*metadata_width_p-1:0] cache_req_metadata_i,
    input  logic [1:0]                    cache_req_metadata_v_i,
    output logic [1:0]                    cache_req_complete_o,
    output logic [1:0]                    cache_req_critical_o,
    output logic [req_width_p-1:0]        lce_req_o,
    output logic                          lce_req_v_o,
    input  logic                          lce_req_ready_i,
    output logic [metadata_width_p-1:0]   lce_req_metadata_o,
    output logic                          lce_req_metadata_v_o,
    input  logic                          lce_req_complete_i,
    input  logic                          lce_req_critical_i
);
    typedef enum logic [1:0] {S_READY, S_META, S_BUSY} state_t;
    state_t r_state, w_state_n;
    logic   r_grant, r_prio, w_sel, w_hs;
    // Contended cycles follow the pointer; otherwise the lone valid requester wins
    assign w_sel = (cache_req_v_i == 2'b11) ? r_prio : cache_req_v_i[1];
    assign w_hs  = (r_state == S_READY) && (|cache_req_v_i) && lce_req_ready_i;
    assign lce_req_o          = w_sel ? cache_req_i[2*req_width_p-1:req_width_p] : cache_req_i[req_width_p-1:0];
    assign lce_req_metadata_o = r_grant ? cache_req_metadata_i[2*metadata_width_p-1:metadata_width_p]
                                        : cache_req_metadata_i[metadata_width_p-1:0];
    // Next state and handshake outputs; everything is forced low while reset is held
    always_comb begin
        w_state_n            = r_state;
        lce_req_v_o          = 1'b0;
        cache_req_ready_o    = 2'b00;
        lce_req_metadata_v_o = 1'b0;
        cache_req_complete_o = 2'b00;
        cache_req_critical_o = 2'b00;
        case (r_state)
            S_READY: begin
                lce_req_v_o              = reset_n_i && (|cache_req_v_i);
                cache_req_ready_o[w_sel] = reset_n_i && lce_req_ready_i;
                w_state_n                = w_hs ? S_META : S_READY;
            end
            S_META: begin
                lce_req_metadata_v_o = reset_n_i && cache_req_metadata_v_i[r_grant];
                w_state_n            = cache_req_metadata_v_i[r_grant] ? S_BUSY : S_META;
            end
            S_BUSY: begin
                cache_req_critical_o[r_grant] = reset_n_i && lce_req_critical_i;
                cache_req_complete_o[r_grant] = reset_n_i && lce_req_complete_i;
                w_state_n                     = lce_req_complete_i ? S_READY : S_BUSY;
            end
            default: w_state_n = S_READY;
        endcase
    end
    // State, grant and priority pointer; pointer moves to the loser on each accepted request
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_READY;
            r_grant <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_hs) begin
                r_grant <= w_sel;
                r_prio  <= ~w_sel;
            end
        end
    end
endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// tb_bp_cache_req_arbiter: directed scenario checks for bp_cache_req_arbiter
module tb_bp_cache_req_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] req;
    logic [1:0]   v, mdv, ready_o, compl_o, crit_o;
    logic [15:0]  md;
    logic [63:0]  lce_req;
    logic         lce_v, rdy, lce_md_v, compl, crit;
    logic [7:0]   lce_md;
    int           errs = 0;
    int           checks = 0;

    bp_cache_req_arbiter #(.req_width_p(64), .metadata_width_p(8)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .cache_req_i(req), .cache_req_v_i(v), .cache_req_ready_o(ready_o),
        .cache_req_metadata_i(md), .cache_req_metadata_v_i(mdv),
        .cache_req_complete_o(compl_o), .cache_req_critical_o(crit_o),
        .lce_req_o(lce_req), .lce_req_v_o(lce_v), .lce_req_ready_i(rdy),
        .lce_req_metadata_o(lce_md), .lce_req_metadata_v_o(lce_md_v),
        .lce_req_complete_i(compl), .lce_req_critical_i(crit)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; v = 2'b11; rdy = 1'b1; mdv = 2'b00; compl = 1'b0; crit = 1'b0;
        req = {64'hDDDD_0000_DDDD_0001, 64'h1111_0000_1111_0002};
        md  = {8'hD5, 8'h15};
        #1;
        checks++; if (lce_v !== 1'b0) begin errs++; $display("FAIL rst_lce_v: got %b want 0", lce_v); end
        checks++; if (ready_o !== 2'b00) begin errs++; $display("FAIL rst_ready: got %b want 00", ready_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (lce_v !== 1'b1) begin errs++; $display("FAIL first_lce_v: got %b want 1", lce_v); end
        checks++; if (ready_o !== 2'b01) begin errs++; $display("FAIL first_grant: got %b want 01", ready_o); end
        checks++; if (lce_req !== 64'h1111_0000_1111_0002) begin errs++; $display("FAIL first_req: got %h want %h", lce_req, 64'h1111_0000_1111_0002); end
        v = 2'b00;
    endtask

    task automatic test_alternate;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  em;
            logic [63:0] er;
            logic [7:0]  emd;
            em  = i[0] ? 2'b10 : 2'b01;
            er  = i[0] ? 64'hDDDD_0000_DDDD_0001 : 64'h1111_0000_1111_0002;
            emd = i[0] ? 8'hD5 : 8'h15;
            @(negedge clk); v = 2'b11; rdy = 1'b1; #1;
            checks++; if (ready_o !== em) begin errs++; $display("FAIL alt_grant%0d: got %b want %b", i, ready_o, em); end
            checks++; if (lce_req !== er) begin errs++; $display("FAIL alt_req%0d: got %h want %h", i, lce_req, er); end
            @(negedge clk); v = 2'b00; mdv = 2'b11; #1;
            checks++; if (lce_md_v !== 1'b1) begin errs++; $display("FAIL alt_mdv%0d: got %b want 1", i, lce_md_v); end
            checks++; if (lce_md !== emd) begin errs++; $display("FAIL alt_md%0d: got %h want %h", i, lce_md, emd); end
            @(negedge clk); mdv = 2'b00; #1;
            checks++; if (compl_o !== 2'b00) begin errs++; $display("FAIL alt_idle%0d: got %b want 00", i, compl_o); end
            @(negedge clk); compl = 1'b1; #1;
            checks++; if (compl_o !== em) begin errs++; $display("FAIL alt_compl%0d: got %b want %b", i, compl_o, em); end
            @(negedge clk); compl = 1'b0;
        end
    endtask

    task automatic test_hold;
        v = 2'b10; rdy = 1'b0; req[127:64] = 64'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (lce_req !== 64'h1234) begin errs++; $display("FAIL hold_req%0d: got %h want 1234", i, lce_req); end
            checks++; if (ready_o !== 2'b00 || lce_v !== 1'b1) begin errs++; $display("FAIL hold_vr%0d: got %b/%b want 00/1", i, ready_o, lce_v); end
        end
        @(negedge clk); rdy = 1'b1; #1;
        checks++; if (ready_o !== 2'b10) begin errs++; $display("FAIL hold_accept: got %b want 10", ready_o); end
        checks++; if (lce_req !== 64'h1234) begin errs++; $display("FAIL hold_accept_req: got %h want 1234", lce_req); end
        @(negedge clk); v = 2'b11; #1;
        checks++; if (lce_v !== 1'b0 || ready_o !== 2'b00) begin errs++; $display("FAIL hold_meta: got %b/%b want 0/00", lce_v, ready_o); end
    endtask

    task automatic test_meta_ignore;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mdv = 2'b01; #1;
            checks++; if (lce_md_v !== 1'b0) begin errs++; $display("FAIL meta_ignore%0d: got %b want 0", i, lce_md_v); end
        end
        @(negedge clk); mdv = 2'b10; #1;
        checks++; if (lce_md_v !== 1'b1) begin errs++; $display("FAIL meta_still: got %b want 1", lce_md_v); end
        checks++; if (lce_md !== 8'hD5) begin errs++; $display("FAIL meta_data: got %h want d5", lce_md); end
    endtask

    task automatic test_crit_complete;
        @(negedge clk); mdv = 2'b00; v = 2'b00; crit = 1'b1; compl = 1'b1; #1;
        checks++; if (crit_o !== 2'b10) begin errs++; $display("FAIL cc_crit: got %b want 10", crit_o); end
        checks++; if (compl_o !== 2'b10) begin errs++; $display("FAIL cc_compl: got %b want 10", compl_o); end
        @(negedge clk); crit = 1'b0; compl = 1'b0; v = 2'b11; #1;
        checks++; if (ready_o !== 2'b01) begin errs++; $display("FAIL cc_ready_next: got %b want 01", ready_o); end
        v = 2'b00;
    endtask

    task automatic test_complete_ignored;
        compl = 1'b1; #1;
        checks++; if (compl_o !== 2'b00 || lce_v !== 1'b0) begin errs++; $display("FAIL ign_ready: got %b/%b want 00/0", compl_o, lce_v); end
        @(negedge clk); compl = 1'b0; v = 2'b01; rdy = 1'b1; #1;
        checks++; if (ready_o !== 2'b01) begin errs++; $display("FAIL ign_still_ready: got %b want 01", ready_o); end
        @(negedge clk); v = 2'b00; compl = 1'b1; crit = 1'b1; #1;
        checks++; if (compl_o !== 2'b00 || crit_o !== 2'b00) begin errs++; $display("FAIL ign_meta: got %b/%b want 00/00", compl_o, crit_o); end
        @(negedge clk); compl = 1'b0; crit = 1'b0; mdv = 2'b01; #1;
        checks++; if (lce_md_v !== 1'b1) begin errs++; $display("FAIL ign_still_meta: got %b want 1", lce_md_v); end
    endtask

    task automatic test_reset_busy;
        @(negedge clk); mdv = 2'b00; crit = 1'b1; compl = 1'b1; #1;
        checks++; if (compl_o !== 2'b01 || crit_o !== 2'b01) begin errs++; $display("FAIL rb_pre: got %b/%b want 01/01", compl_o, crit_o); end
        #2 rst_n = 1'b0; #1;
        checks++; if (compl_o !== 2'b00 || crit_o !== 2'b00) begin errs++; $display("FAIL rb_async: got %b/%b want 00/00", compl_o, crit_o); end
        @(negedge clk); crit = 1'b0; compl = 1'b0; rst_n = 1'b1; v = 2'b11; rdy = 1'b1; #1;
        checks++; if (ready_o !== 2'b01) begin errs++; $display("FAIL rb_regrant: got %b want 01", ready_o); end
        v = 2'b00;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_hold();
        test_meta_ignore();
        test_crit_complete();
        test_complete_ignored();
        test_reset_busy();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
